// File: rtl/xtal32k_pkg.sv
// rtl/xtal32k_pkg.sv - shared state encoding and default parameters for the 32 kHz crystal controller
package xtal32k_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_START  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } xtal32k_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_BOOST_EDGES   = 256;
  localparam int DEF_SETTLE_EDGES  = 1024;
  localparam int DEF_START_TIMEOUT = 1 << 22;
  localparam int DEF_EDGE_TIMEOUT  = 2048;
  localparam int DEF_RETRY_CYCLES  = 1 << 16;
  localparam int DEF_CNT_W         = 24;

endpackage

// File: rtl/xtal32k_sync.sv
// rtl/xtal32k_sync.sv - synchronizer chain and registered rising-edge detect for the 32 kHz clock
module xtal32k_sync
  import xtal32k_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic tick
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      tick  <= chain[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/xtal32k_ctrl.sv
// rtl/xtal32k_ctrl.sv - start-up sequencer and loss-of-clock monitor for the 32 kHz crystal
// Optional auto-retry out of FAULT is built when XTAL32K_AUTORETRY_EN is defined.
module xtal32k_ctrl
  import xtal32k_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int BOOST_EDGES   = DEF_BOOST_EDGES,
  parameter int SETTLE_EDGES  = DEF_SETTLE_EDGES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int EDGE_TIMEOUT  = DEF_EDGE_TIMEOUT,
  parameter int RETRY_CYCLES  = DEF_RETRY_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             xtal_dout,
  output logic             xtal_ena,
  output logic             xtal_boost,
  output logic             clk32_tick,
  output logic             clk_good,
  output logic             fault,
  output logic [CNT_W-1:0] period,
  output logic [2:0]       state
);

  if (SYNC_STAGES < 2 || RETRY_CYCLES < 1 || CNT_W < 2) begin : g_bad_params
    $error("xtal32k_ctrl: invalid parameters");
  end

  localparam logic [CNT_W-1:0] BOOST_LAST  = CNT_W'(BOOST_EDGES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EDGES - 1);
  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EDGE_LAST   = CNT_W'(EDGE_TIMEOUT - 1);

  xtal32k_state_t   st, nxt;
  logic [CNT_W-1:0] wd, ecnt;
  logic             first, active, timeout, edges_done, enter_start;

  xtal32k_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (xtal_dout),
    .tick (clk32_tick)
  );

`ifdef XTAL32K_AUTORETRY_EN
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);
  logic [CNT_W-1:0] retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              retry <= '0;
    else if (st != ST_FAULT) retry <= '0;
    else                     retry <= retry + 1'b1;
  end
`endif

  // A tick landing on the watchdog limit wins: the edge was on time.
  always_comb begin
    active     = (st == ST_START) || (st == ST_SETTLE) || (st == ST_RUN);
    timeout    = active && !clk32_tick && (wd == ((st == ST_START) ? START_LAST : EDGE_LAST));
    edges_done = clk32_tick && (ecnt == ((st == ST_START) ? BOOST_LAST : SETTLE_LAST));
    nxt        = st;
    if (!en) begin
      nxt = ST_OFF;
    end else begin
      case (st)
        ST_OFF:    nxt = ST_START;
        ST_START:  if (timeout) nxt = ST_FAULT; else if (edges_done) nxt = ST_SETTLE;
        ST_SETTLE: if (timeout) nxt = ST_FAULT; else if (edges_done) nxt = ST_RUN;
        ST_RUN:    if (timeout) nxt = ST_FAULT;
        ST_FAULT: begin
`ifdef XTAL32K_AUTORETRY_EN
          if (retry == RETRY_LAST) nxt = ST_START;
`endif
        end
        default:   nxt = ST_OFF;
      endcase
    end
    enter_start = (nxt == ST_START) && (st != ST_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_OFF;
      xtal_ena   <= 1'b0;
      xtal_boost <= 1'b0;
      clk_good   <= 1'b0;
      fault      <= 1'b0;
      period     <= '0;
      wd         <= '0;
      ecnt       <= '0;
      first      <= 1'b0;
    end else begin
      st         <= nxt;
      xtal_ena   <= (nxt == ST_START) || (nxt == ST_SETTLE) || (nxt == ST_RUN);
      xtal_boost <= (nxt == ST_START);
      clk_good   <= (nxt == ST_RUN);

      if (enter_start)          fault <= 1'b0;
      else if (nxt == ST_FAULT) fault <= 1'b1;

      if (enter_start || !active || clk32_tick) wd <= '0;
      else                                      wd <= wd + 1'b1;

      if (enter_start || (st == ST_START && nxt == ST_SETTLE)) ecnt <= '0;
      else if (active && clk32_tick && ecnt != '1)             ecnt <= ecnt + 1'b1;

      // The first edge after START entry has no valid predecessor to measure from.
      if (enter_start)              first <= 1'b1;
      else if (active && clk32_tick) first <= 1'b0;

      if (active && clk32_tick && !first) period <= wd + 1'b1;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_xtal32k_ctrl.sv
// tb/tb_xtal32k_ctrl.sv - directed bench with an event-time reference model for xtal32k_ctrl
module tb_xtal32k_ctrl;

  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          xtal_dout;
  logic          xtal_ena, xtal_boost, clk32_tick, clk_good, fault;
  logic [CW-1:0] period;
  logic [2:0]    state;

  always #5 clk = ~clk;

  xtal32k_ctrl #(
    .SYNC_STAGES  (2),
    .BOOST_EDGES  (4),
    .SETTLE_EDGES (8),
    .START_TIMEOUT(1000),
    .EDGE_TIMEOUT (100),
    .RETRY_CYCLES (50),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .xtal_dout (xtal_dout),
    .xtal_ena  (xtal_ena),
    .xtal_boost(xtal_boost),
    .clk32_tick(clk32_tick),
    .clk_good  (clk_good),
    .fault     (fault),
    .period    (period),
    .state     (state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Oscillator: toggles every 'half' cycles, 3 ns after the clock edge
  logic osc_on = 1'b0;
  int   half   = 25;
  int   ph     = 0;
  initial begin
    xtal_dout = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (!osc_on) begin
        xtal_dout = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          xtal_dout = ~xtal_dout;
        end
      end
    end
  end

  // Reference model in terms of event times: mode 0=off 1=running 2=fault
  int       m_mode = 0, m_nticks = 0, m_last_evt = 0, m_prev_tick = -1, m_fault_cyc = 0, m_period = 0;
  bit       m_fault = 1'b0, m_tick = 1'b0;
  bit [3:0] m_hist = '0;

  function automatic int exp_state();
    if (m_mode == 0) return 0;
    if (m_mode == 2) return 4;
    if (m_nticks < 4) return 1;
    if (m_nticks < 12) return 2;
    return 3;
  endfunction

  task automatic model_start(input int p);
    m_mode = 1; m_nticks = 0; m_last_evt = p; m_prev_tick = -1; m_fault = 1'b0;
  endtask

  task automatic model_step();
    bit t;
    int p, limit;
    t = m_tick;
    p = cyc;
    m_hist = {m_hist[2:0], xtal_dout};
    m_tick = m_hist[2] & ~m_hist[3];
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      model_start(p);
    end else if (m_mode == 1) begin
      limit = (m_nticks < 4) ? 1000 : 100;
      if (t) begin
        m_nticks++;
        if (m_prev_tick >= 0) m_period = p - m_prev_tick;
        m_prev_tick = p;
        m_last_evt = p;
      end else if (p - m_last_evt >= limit) begin
        m_mode = 2; m_fault = 1'b1; m_fault_cyc = p;
      end
    end else begin
`ifdef XTAL32K_AUTORETRY_EN
      if (p - m_fault_cyc >= 50) model_start(p);
`endif
    end
  endtask

  // Observed event cycles, used by the literal checks in the scenarios
  int   obs_start = 0, obs_fault = 0, obs_ena_rise = 0, obs_good_rise = 0;
  int   obs_tick_last = 0, obs_twelfth = 0, obs_active_ticks = 0, obs_boost_ticks = 0;
  logic p_state_start = 1'b0, p_state_fault = 1'b0, p_ena = 1'b0, p_good = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_mode = 0; m_fault = 1'b0; m_period = 0; m_hist = '0; m_tick = 1'b0;
      end
      chk("state", state, exp_state());
      chk("xtal_ena", xtal_ena, m_mode == 1);
      chk("xtal_boost", xtal_boost, (m_mode == 1) && (m_nticks < 4));
      chk("clk_good", clk_good, (m_mode == 1) && (m_nticks >= 12));
      chk("fault", fault, m_fault);
      chk("period", period, m_period);
      chk("clk32_tick", clk32_tick, m_tick);

      if (state == 3'd1 && !p_state_start) begin
        obs_start = cyc; obs_active_ticks = 0; obs_boost_ticks = 0;
      end
      if (state == 3'd4 && !p_state_fault) obs_fault = cyc;
      if (xtal_ena && !p_ena) obs_ena_rise = cyc;
      if (clk_good && !p_good) obs_good_rise = cyc;
      if (clk32_tick) begin
        obs_tick_last = cyc;
        if (state inside {3'd1, 3'd2, 3'd3}) begin
          obs_active_ticks++;
          if (obs_active_ticks == 12) obs_twelfth = cyc;
        end
        if (xtal_boost) obs_boost_ticks++;
      end
      p_state_start = (state == 3'd1);
      p_state_fault = (state == 3'd4);
      p_ena = xtal_ena;
      p_good = clk_good;

      if (rst_n) model_step();
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got 0 expected 1");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_ena", xtal_ena, 0);
    chk("reset_period", period, 0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Nominal start-up
    @(posedge clk); #2; osc_on = 1'b1; half = 25; en = 1'b1;
    for (int i = 0; i < 2000 && !clk_good; i++) @(negedge clk);
    #1;
    chk("nominal_good_reached", clk_good, 1);
    chk("nominal_boost_ticks", obs_boost_ticks, 4);
    chk("nominal_good_after_12th_tick", obs_good_rise - obs_twelfth, 1);
    repeat (200) @(negedge clk);
    #1;
    chk("nominal_period", period, 50);
    chk("nominal_state_run", state, 3);

    // Ticks exactly on the watchdog limit
    half = 50;
    repeat (600) @(negedge clk);
    #1;
    chk("boundary_period", period, 100);
    chk("boundary_no_fault", fault, 0);
    chk("boundary_state_run", state, 3);

    // Loss of clock in RUN
    @(posedge clk); #2; osc_on = 1'b0;
    for (int i = 0; i < 400 && state != 3'd4; i++) @(negedge clk);
    #1;
    chk("loss_state_fault", state, 4);
    chk("loss_wd_clear_to_fault", obs_fault - (obs_tick_last + 1), 100);
    @(posedge clk); #2; en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("loss_off_state", state, 0);
    chk("loss_off_fault_sticky", fault, 1);
    @(posedge clk); #2; en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reenable_fault_clear", fault, 0);

    // No start: oscillator still stopped
    for (int i = 0; i < 1200 && state != 3'd4; i++) @(negedge clk);
    #1;
    chk("nostart_latency", obs_fault - obs_start, 1000);
    chk("nostart_ena", xtal_ena, 0);
    chk("nostart_fault", fault, 1);

`ifdef XTAL32K_AUTORETRY_EN
    for (int i = 0; i < 100 && !xtal_ena; i++) @(negedge clk);
    #1;
    chk("retry_latency", obs_ena_rise - obs_fault, 50);
    chk("retry_fault_clear", fault, 0);
`else
    repeat (60) @(negedge clk);
    #1;
    chk("noretry_stays_fault", state, 4);
`endif
    @(posedge clk); #2; en = 1'b0;
    repeat (3) @(negedge clk);

    // Abort during SETTLE by en
    @(posedge clk); #2; osc_on = 1'b1; half = 25; en = 1'b1;
    for (int i = 0; i < 600 && state != 3'd2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_en_in_settle", state, 2);
    @(posedge clk); #2; en = 1'b0;
    @(negedge clk); #1;
    chk("abort_en_same_cycle_ena", xtal_ena, 1);
    @(negedge clk); #1;
    chk("abort_en_next_cycle_ena", xtal_ena, 0);

    // Abort during SETTLE by reset
    @(posedge clk); #2; en = 1'b1;
    for (int i = 0; i < 600 && state != 3'd2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    chk("abort_rst_ena_immediate", xtal_ena, 0);
    chk("abort_rst_state_immediate", state, 0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1; en = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
